// File: rtl/alu_mdu_seq.sv
// Sequential ALU plus RV32M multiply/divide unit with valid/ready handshakes.
// Base ops retire after one edge; M ops iterate one bit per edge (radix-2).
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_m,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rd,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int W2  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_calc = a + b;
      OP_SUB:  alu_calc = a - b;
      OP_SLL:  alu_calc = a << sh;
      OP_SLT:  alu_calc = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_calc = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  alu_calc = a ^ b;
      OP_SRL:  alu_calc = a >> sh;
      OP_SRA:  alu_calc = WIDTH'($signed(a) >>> sh);
      OP_OR:   alu_calc = a | b;
      OP_AND:  alu_calc = a & b;
      default: alu_calc = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic neg, input logic [WIDTH-1:0] x);
    mag = neg ? -x : x;
  endfunction

  // Upper half accumulates partial products, lower half holds the remaining multiplier bits.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] acc,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? b : {WIDTH{1'b0}})};
    mul_step = {sum, acc[WIDTH-1:1]};
  endfunction

  // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
  function automatic logic [W2-1:0] div_step(input logic [W2-1:0] acc,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    diff = sh - {1'b0, b};
    if (!diff[WIDTH]) div_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              div_step = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] mdu_final(input logic is_div, input logic neg,
                                                 input logic hi, input logic [W2-1:0] acc);
    logic [W2-1:0]    p;
    logic [WIDTH-1:0] v;
    p = neg ? -acc : acc;
    v = hi ? acc[W2-1:WIDTH] : acc[WIDTH-1:0];
    if (is_div) mdu_final = neg ? -v : v;
    else        mdu_final = hi ? p[W2-1:WIDTH] : p[WIDTH-1:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             hi_q, hi_d;
  logic [WIDTH-1:0] out_rd_q, out_rd_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [2:0]       f3;
  logic             is_div, s1, s2, neg1, neg2, divz, ovf, accept;
  logic [WIDTH-1:0] mag1, mag2, special;
  logic [W2-1:0]    step_res;

  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_HOLD);
  assign out_rd    = out_rd_q;
  assign out_tag   = out_tag_q;

  assign f3      = in_op[2:0];
  assign is_div  = f3[2];
  assign s1      = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
  assign s2      = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
  assign neg1    = s1 && in_rs1[WIDTH-1];
  assign neg2    = s2 && in_rs2[WIDTH-1];
  assign mag1    = mag(neg1, in_rs1);
  assign mag2    = mag(neg2, in_rs2);
  assign divz    = (in_rs2 == '0);
  assign ovf     = ((f3 == 3'd4) || (f3 == 3'd6)) && (in_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_rs2);
  assign special = divz ? (f3[1] ? in_rs1 : {WIDTH{1'b1}}) : (f3[1] ? {WIDTH{1'b0}} : in_rs1);
  assign step_res = (state_q == S_DIV) ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    out_rd_d  = out_rd_q;
    out_tag_d = out_tag_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      out_tag_d = in_tag;
      if (!in_m) begin
        out_rd_d = alu_calc(in_op, in_rs1, in_rs2);
        state_d  = S_HOLD;
      end else if (is_div && (divz || ovf)) begin
        out_rd_d = special;
        state_d  = S_HOLD;
      end else begin
        state_d = is_div ? S_DIV : S_MUL;
        cnt_d   = CW'(WIDTH);
        hi_d    = is_div ? f3[1] : (f3 != 3'd0);
        // Remainder takes the dividend's sign; quotient and product take the xor.
        neg_d   = (is_div && f3[1]) ? neg1 : (neg1 ^ neg2);
        opb_d   = is_div ? mag2 : mag1;
        acc_d   = {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
      end
    end else begin
      case (state_q)
        S_MUL, S_DIV: begin
          cnt_d = cnt_q - CW'(1);
          acc_d = step_res;
          if (cnt_q == CW'(1)) begin
            out_rd_d = mdu_final(state_q == S_DIV, neg_q, hi_q, step_res);
            state_d  = S_HOLD;
          end
        end
        S_HOLD: if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_rd_q  <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_rd_q  <= out_rd_d;
      out_tag_q <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    opb_q <= opb_d;
    neg_q <= neg_d;
    hi_q  <= hi_d;
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq: base ops, M ops, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_alu_mdu_seq;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
  localparam logic [3:0] SRL = 4'd6, SRA = 4'd7, AND = 4'd9;
  localparam logic [3:0] MUL = 4'd0, MULH = 4'd1, MULHSU = 4'd2, DIV = 4'd4;
  localparam logic [3:0] DIVU = 4'd5, REM = 4'd6, REMU = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_m = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd;
  logic [4:0]  out_tag;

  int n_err = 0;
  int n_chk = 0;

  alu_mdu_seq #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // lat counts edges from (and including) the accept edge until out_valid is seen.
  task automatic run_op(input string nm, input logic m, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                        input logic [31:0] exp, input int lat);
    int n;
    int busy;
    @(negedge clk);
    in_valid = 1'b1; in_m = m; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg;
    out_ready = 1'b1;
    #1 chk($sformatf("%s.in_ready", nm), 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    busy = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) busy++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s.lat", nm), 64'(n), 64'(lat));
    chk($sformatf("%s.busy", nm), 64'(busy), 64'(lat - 1));
    chk($sformatf("%s.rd", nm), 64'(out_rd), 64'(exp));
    chk($sformatf("%s.tag", nm), 64'(out_tag), 64'(tg));
  endtask

  initial begin
    int cnt;
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_rd", 64'(out_rd), 64'd0);
    chk("rst.out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back ADD then SUB
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_m = 1'b0; in_op = ADD; in_rs1 = 32'd10; in_rs2 = -32'sd5; in_tag = 5'd1;
    #1 chk("b2b.rdy0", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("b2b.v0", 64'(out_valid), 64'd1);
    chk("b2b.rd0", 64'(out_rd), 64'h5);
    chk("b2b.tag0", 64'(out_tag), 64'd1);
    in_op = SUB; in_rs1 = -32'sd5; in_rs2 = -32'sd10; in_tag = 5'd2;
    #1 chk("b2b.rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.v1", 64'(out_valid), 64'd1);
    chk("b2b.rd1", 64'(out_rd), 64'h5);
    chk("b2b.tag1", 64'(out_tag), 64'd2);
    @(negedge clk);
    chk("b2b.idle", 64'(out_valid), 64'd0);

    run_op("sra",  1'b0, SRA,   32'hA5A5A5A5, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1);
    run_op("sll",  1'b0, SLL,   32'hBADCAFFE, 32'd4,        5'd4, 32'hADCAFFE0, 1);
    run_op("srl",  1'b0, SRL,   32'h80000000, 32'h21,       5'd5, 32'h40000000, 1);
    run_op("slt",  1'b0, SLT,   32'hFFFFFFFF, 32'd1,        5'd6, 32'd1,        1);
    run_op("sltu", 1'b0, SLTU,  32'hFFFFFFFF, 32'd1,        5'd7, 32'd0,        1);
    run_op("and",  1'b0, AND,   32'h0000F0F0, 32'h0000FF00, 5'd8, 32'h0000F000, 1);
    run_op("bad",  1'b0, 4'hF,  32'h12345678, 32'h1,        5'd9, 32'd0,        1);

    run_op("mulh",   1'b1, MULH,   32'h80000000, 32'h80000000, 5'd10, 32'h40000000, 33);
    run_op("mul",    1'b1, MUL,    32'h80000000, 32'h80000000, 5'd11, 32'h00000000, 33);
    run_op("mulhsu", 1'b1, MULHSU, 32'hFFFFFFFF, 32'd2,        5'd12, 32'hFFFFFFFF, 33);
    run_op("div",    1'b1, DIV,    -32'sd7,      32'd2,        5'd13, 32'hFFFFFFFD, 33);
    run_op("rem",    1'b1, REM,    -32'sd7,      32'd2,        5'd14, 32'hFFFFFFFF, 33);
    run_op("divu",   1'b1, DIVU,   32'hFFFFFFFF, 32'h10,       5'd15, 32'h0FFFFFFF, 33);
    run_op("divovf", 1'b1, DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run_op("remu0",  1'b1, REMU,   32'd5,        32'd0,        5'd17, 32'd5,        1);
    run_op("divu0",  1'b1, DIVU,   32'd7,        32'd0,        5'd18, 32'hFFFFFFFF, 1);

    // Backpressure with a tagged ADD
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_m = 1'b0; in_op = ADD; in_rs1 = 32'd3; in_rs2 = 32'd4; in_tag = 5'h1B;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_op = SUB; in_rs1 = 32'd9; in_rs2 = 32'd2; in_tag = 5'h05;
      end
      #1;
      chk($sformatf("bp.v%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp.rd%0d", i), 64'(out_rd), 64'd7);
      chk($sformatf("bp.tag%0d", i), 64'(out_tag), 64'h1B);
      chk($sformatf("bp.rdy%0d", i), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp.rdy_up", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.next_v", 64'(out_valid), 64'd1);
    chk("bp.next_rd", 64'(out_rd), 64'd7);
    chk("bp.next_tag", 64'(out_tag), 64'h05);

    // Flush ten cycles into a DIV, with a competing request on the flush edge
    @(negedge clk);
    in_valid = 1'b1; in_m = 1'b1; in_op = DIV; in_rs1 = 32'd100; in_rs2 = 32'd3; in_tag = 5'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; in_m = 1'b0; in_op = ADD; in_rs1 = 32'd1; in_rs2 = 32'd1; in_tag = 5'd21;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.v", 64'(out_valid), 64'd0);
    chk("flush.rdy", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush.never_valid", 64'(cnt), 64'd0);

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1; in_m = 1'b1; in_op = MUL; in_rs1 = 32'd3; in_rs2 = 32'd5; in_tag = 5'd22;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst.v", 64'(out_valid), 64'd0);
    chk("mrst.rdy", 64'(in_ready), 64'd0);
    chk("mrst.rd", 64'(out_rd), 64'd0);
    chk("mrst.tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("mrst.dropped", 64'(cnt), 64'd0);
    run_op("post_rst", 1'b1, MUL, 32'd3, 32'd5, 5'd23, 32'd15, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Sequential, parametrised successor to the core's combinational `alu`.
- Registers all ten base ALU ops with a 1-cycle latency.
- Adds the RV32M multiply/divide group, executed iteratively at radix-2.
- Uses valid/ready handshakes on input and output, with a passthrough tag, so the execute stage can stall on it and retire out of a single-entry result register.

Parameters:
- WIDTH, 32, datapath width; must be a power of two and >= 8.
- TAG_W, 5, width of the opaque tag carried from input to output (for example the rd index).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous and active-high.
- in_valid, in, 1, operation request.
- in_ready, out, 1, block can accept the request this cycle.
- in_m, in, 1, 0 = base ALU op, 1 = M-extension op.
- in_op, in, 4, base ALU op enum from datatypes.sv when in_m=0; when in_m=1, in_op[2:0] is funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- in_rs1, in, WIDTH, operand 1.
- in_rs2, in, WIDTH, operand 2.
- in_tag, in, TAG_W, opaque tag.
- flush, in, 1, synchronous abort of any in-flight or held operation.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_rd, out, WIDTH, result.
- out_tag, out, TAG_W, tag of the result.

Behaviour:
- **Reset:** rst high clears the FSM to IDLE, out_valid=0, out_rd=0, out_tag=0 and the counter to 0, without waiting for a clock edge. While rst is high, in_ready=0. Reset mid-operation drops the operation silently.
- **FSM states:** IDLE, MUL, DIV, HOLD.
- **in_ready:** in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational from state and out_ready.
- **Accept:** an operation is accepted on an edge where in_valid && in_ready && !flush. Operands, op and tag are captured at that edge.
- **Base op (in_m=0):**
  - Result computed combinationally and registered on the accept edge; state -> HOLD, out_valid=1 from the next cycle (latency 1).
  - Throughput is 1 per cycle while out_ready=1.
  - Shift amount is rs2[$clog2(WIDTH)-1:0]; upper bits are ignored.
  - SLT is signed and SLTU unsigned; each yields 0 or 1 zero-extended.
  - ADD/SUB wrap modulo 2^WIDTH.
  - An unused op enum yields 0.
- **MUL group:**
  - Operands are converted to magnitudes per signedness: MULH both signed, MULHSU rs1 signed only, MUL/MULHU unsigned.
  - Shift-add runs for WIDTH iterations into a 2*WIDTH product register.
  - The negated product is used when the sign flag is set.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- **DIV group:**
  - Restoring shift-subtract on magnitudes, WIDTH iterations.
  - Quotient sign = s1^s2 (signed ops only); remainder sign = s1.
- **M-op latency:** accept edge -> state MUL/DIV with counter=WIDTH. Counter decrements each edge; on the edge where it reaches 0 the result is registered and state -> HOLD. out_valid therefore rises WIDTH+1 edges after accept. in_ready=0 throughout MUL/DIV.
- **Divide special cases** (fast path, latency 1, no iteration):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = most negative, rs2 = -1): DIV -> rs1, REM -> 0.
- **HOLD:**
  - out_rd and out_tag are stable while out_valid && !out_ready.
  - On out_ready: if a new op is accepted on the same edge it follows the accept rules; otherwise state -> IDLE and out_valid=0.
- **flush:** on the next edge, state -> IDLE, out_valid=0 and the counter is cleared. Any in_valid on that cycle is not accepted, and flush has priority over a simultaneous accept. in_ready returns to 1 the cycle after flush.
- **Output timing:** no combinational path from in_* to out_*.

Test Plan:
- ADD rs1=10, rs2=-5 then SUB rs1=-5, rs2=-10, back-to-back with out_ready=1 -> out_rd 0x00000005 then 0x00000005, each 1 cycle after accept, in_ready held 1.
- SRA rs1=0xA5A5A5A5, rs2=0xFFFFFFFF -> 0xFFFFFFFF. SLL rs1=0xBADCAFFE, rs2=4 -> 0xADCAFFE0.
- MULH rs1=rs2=0x80000000 -> 0x40000000; MUL same operands -> 0x00000000; MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF. For each:
  - out_valid exactly 33 edges after accept;
  - in_ready=0 for the 32 cycles between.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; DIV 0x80000000/-1 -> 0x80000000 with latency 1; REMU 5/0 -> 5 with latency 1.
- Backpressure: out_ready=0 for 5 cycles after a tagged (tag=0x1B) ADD -> out_rd and out_tag stay 0x1B-stable, in_ready=0. Raising out_ready with in_valid=1 accepts the next op on the same edge.
- Flush and reset mid-operation:
  - flush asserted 10 cycles into a DIV -> out_valid never asserts, in_ready=1 the following cycle.
  - rst pulsed mid-MUL (between clock edges) -> out_valid=0 and in_ready=0 immediately.
  - After rst deasserts, the next op completes correctly.
